// File: rtl/pipe_decode_stage.sv
// pipe_decode_stage: instruction decode stage with a REG_N x DATA_W register
// file, ready/valid handshakes on both sides and a registered output bundle.
// Optional feature: define DECODE_FWD_EN to bypass a same-cycle writeback into
// the operands. Without it, a read-after-write hit stalls the stage for one cycle.
module pipe_decode_stage #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 12,
   parameter int REG_N  = 16,
   localparam int AW    = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       inst,
   input  logic [PC_W-1:0]   pc,
   input  logic              imm_sel,
   input  logic              is_branch,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic [AW-1:0]     out_dest,
   output logic [AW-1:0]     out_src1,
   output logic [AW-1:0]     out_src2,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic              out_branch,
   output logic [PC_W-1:0]   out_pc_branch
);

   logic [DATA_W-1:0] regFile [REG_N];
   logic [AW-1:0]     src1Addr;
   logic [AW-1:0]     src2Addr;
   logic [AW-1:0]     destAddr;
   logic [DATA_W-1:0] operand1;
   logic [DATA_W-1:0] operand2;
   logic [PC_W-1:0]   branchTarget;
   logic              wbLive;
   logic              stall;
   logic              accept;

   // Register fields use only their low AW bits; wider field bits are ignored.
   assign src1Addr = inst[8 +: AW];
   assign src2Addr = inst[4 +: AW];
   assign destAddr = inst[0 +: AW];

   // Writes to register 0 are dropped, so it never takes part in hazards.
   assign wbLive = wb_en && (wb_addr != '0);

`ifdef DECODE_FWD_EN
   // Forwarding covers every same-cycle hit, so the stage never stalls.
   assign stall = 1'b0;
`else
   logic wbHit;
   logic stallQ;

   // An immediate operand replaces src2, so only src1 can hit in that case.
   assign wbHit = wbLive && ((wb_addr == src1Addr) || (!imm_sel && (wb_addr == src2Addr)));
   assign stall = in_valid && wbHit && !stallQ;

   // Remember the stall so the retried instruction is accepted the next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallQ <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
         stallQ <= stall;
      end
   end
`endif

   assign in_ready = reset && (!out_valid || out_ready) && !stall && !flush;
   assign accept   = in_valid && in_ready;

   // Operand selection: register read, optional bypass, immediate override.
   always_comb begin
      // NOTE: defaults first so no path through the block leaves a latch.
      operand1 = (src1Addr == '0) ? '0 : regFile[src1Addr];
      operand2 = (src2Addr == '0) ? '0 : regFile[src2Addr];
`ifdef DECODE_FWD_EN
      if (wbLive && (wb_addr == src1Addr)) operand1 = wb_data;
      if (wbLive && (wb_addr == src2Addr)) operand2 = wb_data;
`endif
      if (imm_sel) operand2 = DATA_W'(inst[7:0]);
   end

   // Branch target wraps modulo 2^PC_W; non-branches carry a zero target.
   assign branchTarget = is_branch ? (pc + PC_W'($signed(inst[3:0]))) : '0;

   // Register file write port; register 0 is never written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the register file is plain flops and must read as zero after reset, so it is cleared here.
         for (int i = 0; i < REG_N; i++) regFile[i] <= '0;
      end else if (wbLive) begin
         regFile[wb_addr] <= wb_data;
      end
   end

   // Output bundle: loads on accept, holds otherwise; flush drops the valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         out_opcode    <= '0;
         out_dest      <= '0;
         out_src1      <= '0;
         out_src2      <= '0;
         out_data1     <= '0;
         out_data2     <= '0;
         out_branch    <= 1'b0;
         out_pc_branch <= '0;
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (accept)    out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;

         if (accept) begin
            out_opcode    <= inst[15:12];
            out_dest      <= destAddr;
            out_src1      <= src1Addr;
            out_src2      <= src2Addr;
            out_data1     <= operand1;
            out_data2     <= operand2;
            out_branch    <= is_branch;
            out_pc_branch <= branchTarget;
         end
      end
   end

endmodule

// File: tb/tb_pipe_decode_stage.sv
// Testbench for pipe_decode_stage (default parameters). Directed vectors with
// literal expectations plus a per-cycle comparison against a behavioural model.
// Build with or without DECODE_FWD_EN to match the RTL build.
module tb_pipe_decode_stage;

   localparam int DATA_W = 16;
   localparam int PC_W   = 12;
   localparam int REG_N  = 16;
   localparam int AW     = 4;
`ifdef DECODE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       inst;
   logic [PC_W-1:0]   pc;
   logic              imm_sel;
   logic              is_branch;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_opcode;
   logic [AW-1:0]     out_dest;
   logic [AW-1:0]     out_src1;
   logic [AW-1:0]     out_src2;
   logic [DATA_W-1:0] out_data1;
   logic [DATA_W-1:0] out_data2;
   logic              out_branch;
   logic [PC_W-1:0]   out_pc_branch;

   always #5 clk = ~clk;

   pipe_decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_N(REG_N)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .pc(pc), .imm_sel(imm_sel), .is_branch(is_branch),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_dest(out_dest),
      .out_src1(out_src1), .out_src2(out_src2),
      .out_data1(out_data1), .out_data2(out_data2),
      .out_branch(out_branch), .out_pc_branch(out_pc_branch)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] mRf [16];
   logic        mValid;
   logic [3:0]  mOpcode, mDest, mSrc1, mSrc2;
   logic [15:0] mData1, mData2;
   logic        mBranch;
   logic [11:0] mTarget;
   logic        mStalledLast;

   // A writeback colliding with a read source costs one cycle unless bypassed.
   function automatic logic mStall();
      logic hit;
      hit = in_valid && wb_en && (wb_addr != 0) &&
            ((wb_addr == inst[11:8]) || (!imm_sel && (wb_addr == inst[7:4])));
      return !FWD && hit && !mStalledLast;
   endfunction

   function automatic logic mReady();
      return reset && (!mValid || out_ready) && !mStall() && !flush;
   endfunction

   function automatic logic [15:0] readModel(input logic [3:0] a);
      if (a == 0) return 16'h0000;
      if (FWD && wb_en && (wb_addr == a)) return wb_data;
      return mRf[a];
   endfunction

   always @(posedge clk or negedge reset) begin
      logic acc;
      logic stallNow;
      if (!reset) begin
         for (int i = 0; i < 16; i++) mRf[i] <= 16'h0000;
         mValid <= 1'b0; mOpcode <= 0; mDest <= 0; mSrc1 <= 0; mSrc2 <= 0;
         mData1 <= 0; mData2 <= 0; mBranch <= 0; mTarget <= 0; mStalledLast <= 0;
      end else begin
         stallNow = mStall();
         acc      = in_valid && mReady();
         if (acc) begin
            mOpcode <= inst[15:12];
            mSrc1   <= inst[11:8];
            mSrc2   <= inst[7:4];
            mDest   <= inst[3:0];
            mData1  <= readModel(inst[11:8]);
            mData2  <= imm_sel ? {8'h00, inst[7:0]} : readModel(inst[7:4]);
            mBranch <= is_branch;
            mTarget <= is_branch ? (pc + {{8{inst[3]}}, inst[3:0]}) : 12'h000;
         end
         mValid <= flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : mValid;
         if (wb_en && (wb_addr != 0)) mRf[wb_addr] <= wb_data;
         mStalledLast <= stallNow;
      end
   end

   // Per-cycle comparison, sampled 1 time unit after the falling edge.
   always @(negedge clk) begin
      #1;
      check("in_ready",      in_ready,      mReady());
      check("out_valid",     out_valid,     mValid);
      check("out_opcode",    out_opcode,    mOpcode);
      check("out_dest",      out_dest,      mDest);
      check("out_src1",      out_src1,      mSrc1);
      check("out_src2",      out_src2,      mSrc2);
      check("out_data1",     out_data1,     mData1);
      check("out_data2",     out_data2,     mData2);
      check("out_branch",    out_branch,    mBranch);
      check("out_pc_branch", out_pc_branch, mTarget);
   end

   // ---------------- stimulus ----------------
   // Advance to the falling edge and return all inputs to their idle values.
   task automatic cyc();
      @(negedge clk);
      in_valid  = 1'b0;
      wb_en     = 1'b0;
      flush     = 1'b0;
      imm_sel   = 1'b0;
      is_branch = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 0; inst = 0; pc = 0; imm_sel = 0; is_branch = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
      #2 reset = 1'b0;
      @(negedge clk); #2;
      check("lit ready in reset", in_ready, 1'b0);
      check("lit valid in reset", out_valid, 1'b0);
      @(negedge clk); reset = 1'b1;
      #2 check("lit ready after release", in_ready, 1'b1);

      // R3 = 0x1234, then decode 0x1305
      cyc(); wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
      cyc(); in_valid = 1; inst = 16'h1305; pc = 12'h010;
      #2 check("lit accept 1305", in_ready, 1'b1);
      cyc(); #2;
      check("lit valid 1305", out_valid, 1'b1);
      check("lit data1 1305", out_data1, 16'h1234);
      check("lit src2 1305",  out_src2,  4'h0);
      check("lit data2 1305", out_data2, 16'h0000);
      check("lit dest 1305",  out_dest,  4'h5);

      // immediate operand
      cyc(); wb_en = 1; wb_addr = 10; wb_data = 16'hA5A5;
      cyc(); in_valid = 1; imm_sel = 1; inst = 16'h2A7F;
      cyc(); #2;
      check("lit imm data1", out_data1, 16'hA5A5);
      check("lit imm data2", out_data2, 16'h007F);

      // backpressure for three cycles
      cyc(); in_valid = 1; inst = 16'h4123;
      repeat (3) begin
         cyc(); out_ready = 0; in_valid = 1; inst = 16'h5234; #2;
         check("lit hold ready", in_ready, 1'b0);
         check("lit hold opcode", out_opcode, 4'h4);
         check("lit hold valid", out_valid, 1'b1);
      end
      cyc(); in_valid = 1; inst = 16'h5234; #2;
      check("lit release ready", in_ready, 1'b1);
      cyc(); #2 check("lit next opcode", out_opcode, 4'h5);

      // branch targets
      cyc(); in_valid = 1; is_branch = 1; pc = 12'h002; inst = 16'h600E;
      cyc(); in_valid = 1; is_branch = 1; pc = 12'hFFF; inst = 16'h6001; #2;
      check("lit branch flag", out_branch, 1'b1);
      check("lit target 002-2", out_pc_branch, 12'h000);
      cyc(); in_valid = 1; pc = 12'h100; inst = 16'h6007; #2;
      check("lit target wrap", out_pc_branch, 12'h000);
      cyc(); in_valid = 1; is_branch = 1; pc = 12'h100; inst = 16'h6007; #2;
      check("lit nonbranch flag", out_branch, 1'b0);
      check("lit nonbranch target", out_pc_branch, 12'h000);
      cyc(); #2 check("lit target 107", out_pc_branch, 12'h107);

      // same-cycle writeback hit on src1
      cyc(); wb_en = 1; wb_addr = 4; wb_data = 16'h1111;
      cyc(); wb_en = 1; wb_addr = 4; wb_data = 16'hBEEF; in_valid = 1; inst = 16'h7400; #2;
      check("lit hit ready", in_ready, FWD ? 1'b1 : 1'b0);
`ifndef DECODE_FWD_EN
      cyc(); in_valid = 1; inst = 16'h7400; #2;
      check("lit retry ready", in_ready, 1'b1);
`endif
      cyc(); #2;
      check("lit hit valid", out_valid, 1'b1);
      check("lit hit data1", out_data1, 16'hBEEF);

      // immediate suppresses a src2 match
      cyc(); wb_en = 1; wb_addr = 5; wb_data = 16'h5555; in_valid = 1; imm_sel = 1; inst = 16'h8056; #2;
      check("lit imm no stall", in_ready, 1'b1);
      cyc(); #2 check("lit imm data2 56", out_data2, 16'h0056);

      // src2 hit without immediate
      cyc(); wb_en = 1; wb_addr = 5; wb_data = 16'h6666; in_valid = 1; inst = 16'h8051;
`ifndef DECODE_FWD_EN
      cyc(); in_valid = 1; inst = 16'h8051;
`endif
      cyc(); #2 check("lit src2 hit data2", out_data2, 16'h6666);

      // flush with a valid bundle and an offered instruction
      cyc(); in_valid = 1; inst = 16'hA123;
      cyc(); flush = 1; out_ready = 0; in_valid = 1; inst = 16'hB456; #2;
      check("lit flush ready", in_ready, 1'b0);
      check("lit flush valid before", out_valid, 1'b1);
      cyc(); #2;
      check("lit flush valid after", out_valid, 1'b0);
      check("lit flush opcode", out_opcode, 4'hA);

      // streaming with unrelated writebacks
      for (int i = 1; i < 8; i++) begin
         cyc(); in_valid = 1; inst = {4'(i), 4'(i), 4'(i + 1), 4'(i)};
         wb_en = (i % 2) == 1; wb_addr = 4'(i + 8); wb_data = 16'(i * 257);
      end

      // asynchronous reset mid-stream
      cyc(); in_valid = 1; inst = 16'hC300;
      cyc(); wb_en = 1; wb_addr = 6; wb_data = 16'h7777;
      #3 reset = 1'b0;
      #1;
      check("lit rst valid", out_valid, 1'b0);
      check("lit rst opcode", out_opcode, 4'h0);
      check("lit rst data1", out_data1, 16'h0000);
      check("lit rst src1", out_src1, 4'h0);
      check("lit rst ready", in_ready, 1'b0);
      cyc(); wb_en = 1; wb_addr = 6; wb_data = 16'h7777;
      cyc(); reset = 1'b1; wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF; in_valid = 1; inst = 16'hD000; #2;
      check("lit r0 no stall", in_ready, 1'b1);
      cyc(); in_valid = 1; inst = 16'hD360;
      cyc(); #2;
      check("lit r3 cleared", out_data1, 16'h0000);
      check("lit r6 not written", out_data2, 16'h0000);
      cyc(); in_valid = 1; inst = 16'hE000;
      cyc(); #2 check("lit r0 reads zero", out_data1, 16'h0000);
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
